// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle MIPS datapath sharing one memory and one ALU.
// Memory waits are guarded by a watchdog that parks the FSM in ERR.
module multicycle_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opc,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic [1:0] o_reg_dst,
    output logic [1:0] o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_src,
    output logic       o_pc_write,
    output logic       o_illegal_op,
    output logic       o_err,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_IF      = 4'd1,
        S_ID      = 4'd2,
        S_EX_R    = 4'd3,
        S_WB_R    = 4'd4,
        S_EX_I    = 4'd5,
        S_WB_I    = 4'd6,
        S_MEM_ADR = 4'd7,
        S_MEM_LW  = 4'd8,
        S_WB_LW   = 4'd9,
        S_MEM_SW  = 4'd10,
        S_BR      = 4'd11,
        S_JMP     = 4'd12,
        S_JAL     = 4'd13,
        S_ERR     = 4'd14
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] LP_MAX  = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wdCnt;
    logic             w_isWait;
    logic             w_timeout;

    assign w_isWait  = (r_state == S_IF) || (r_state == S_MEM_LW) || (r_state == S_MEM_SW);
    assign w_timeout = (TIMEOUT != 0) && w_isWait && !i_mem_ready && (r_wdCnt == LP_LAST);
    assign o_state   = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Every exit from a wait state needs mem_ready=1, so holding the count at
    // zero outside wait states also gives the clear-on-entry behaviour.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdCnt <= '0;
        end else if (!w_isWait || i_mem_ready) begin
            r_wdCnt <= '0;
        end else if (r_wdCnt != LP_MAX) begin
            r_wdCnt <= r_wdCnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:     w_next = S_IF;
            S_IF:      w_next = i_mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (i_opc)
                    OP_R:            w_next = S_EX_R;
                    OP_ADDI, OP_ANDI: w_next = S_EX_I;
                    OP_LW, OP_SW:    w_next = S_MEM_ADR;
                    OP_BEQ, OP_BNE:  w_next = S_BR;
                    OP_J:            w_next = S_JMP;
                    OP_JAL:          w_next = S_JAL;
                    default:         w_next = S_IF;
                endcase
            end
            S_EX_R:    w_next = S_WB_R;
            S_EX_I:    w_next = S_WB_I;
            S_MEM_ADR: w_next = (i_opc == OP_SW) ? S_MEM_SW : S_MEM_LW;
            S_MEM_LW:  w_next = i_mem_ready ? S_WB_LW : S_MEM_LW;
            S_MEM_SW:  w_next = i_mem_ready ? S_IF : S_MEM_SW;
            S_ERR:     w_next = S_ERR;
            default:   w_next = S_IF;
        endcase
        if (w_timeout) begin
            w_next = S_ERR;
        end
    end

    always_comb begin
        o_iord       = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_dst    = 2'b00;
        o_mem_to_reg = 2'b00;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b00;
        o_pc_src     = 2'b00;
        o_pc_write   = 1'b0;
        o_illegal_op = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            S_IF: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = 2'b01;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_ID: begin
                o_alu_src_b = 2'b11;
                case (i_opc)
                    OP_R, OP_ADDI, OP_ANDI, OP_LW, OP_SW,
                    OP_BEQ, OP_BNE, OP_J, OP_JAL: o_illegal_op = 1'b0;
                    default:                      o_illegal_op = 1'b1;
                endcase
            end
            S_EX_R: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = 2'b10;
            end
            S_WB_R: begin
                o_reg_dst   = 2'b01;
                o_reg_write = 1'b1;
            end
            S_EX_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_op    = (i_opc == OP_ANDI) ? 2'b11 : 2'b00;
            end
            S_WB_I: begin
                o_reg_write = 1'b1;
            end
            S_MEM_ADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
            end
            S_MEM_LW: begin
                o_iord     = 1'b1;
                o_mem_read = 1'b1;
            end
            S_WB_LW: begin
                o_mem_to_reg = 2'b01;
                o_reg_write  = 1'b1;
            end
            S_MEM_SW: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            S_BR: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = 2'b01;
                o_pc_src    = 2'b01;
                o_pc_write  = (i_opc == OP_BNE) ? ~i_zero : i_zero;
            end
            S_JMP: begin
                o_pc_src   = 2'b10;
                o_pc_write = 1'b1;
            end
            // r31 takes PC (already PC+4) while PC loads the jump target.
            S_JAL: begin
                o_pc_src     = 2'b10;
                o_pc_write   = 1'b1;
                o_reg_write  = 1'b1;
                o_reg_dst    = 2'b10;
                o_mem_to_reg = 2'b10;
            end
            S_ERR: begin
                o_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
